// File: rtl/fwd_hazard_if.sv
// Bus bundle for fwd_hazard_tracker: decode-side issue, stage result buses, read ports and status outputs.
interface fwd_hazard_if #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int STAGES = 3,
  parameter int NRD    = 2,
  parameter int TW     = 2
);
  // Handshake: issue_valid qualifies issue_a3/issue_tnew for one cycle. The write is
  // accepted on the rising edge only when stall is low in that cycle (stall acts as
  // the inverted ready). A request offered while stall is high is dropped, and decode
  // must present it again.
  logic                 flush;
  logic                 issue_valid;
  logic [AW-1:0]        issue_a3;
  logic [TW-1:0]        issue_tnew;
  logic [STAGES*DW-1:0] stage_wd;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*TW-1:0]    rd_tuse;
  logic [NRD*DW-1:0]    rd_val0;
  logic [NRD*DW-1:0]    rd_val1;
  logic [NRD-1:0]       rd_pending;
  logic                 stall;
  logic [31:0]          stall_cnt;
  logic [31:0]          fwd_cnt;

  modport master (
    output flush, issue_valid, issue_a3, issue_tnew, stage_wd, rd_addr, rd_tuse, rd_val0,
    input  rd_val1, rd_pending, stall, stall_cnt, fwd_cnt
  );

  modport slave (
    input  flush, issue_valid, issue_a3, issue_tnew, stage_wd, rd_addr, rd_tuse, rd_val0,
    output rd_val1, rd_pending, stall, stall_cnt, fwd_cnt
  );
endinterface

// File: rtl/fwd_hazard_tracker.sv
// Tnew/Tuse hazard tracker and forwarding unit beside decode.
// Optional statistics counters are built when FWD_STATS_EN is defined.
module fwd_hazard_tracker #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int STAGES = 3,
  parameter int NRD    = 2,
  parameter int TW     = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fwd_hazard_if.slave   bus
);

  logic [STAGES-1:0] ent_v;
  logic [AW-1:0]     ent_a3   [STAGES];
  logic [TW-1:0]     ent_tnew [STAGES];

  logic [NRD-1:0] match;
  logic [NRD-1:0] fwd;
  logic [TW-1:0]  m_tnew [NRD];
  logic [DW-1:0]  m_wd   [NRD];
  logic           stall_int;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Entries keep shifting while stalled; only the decode-side insert becomes a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_v <= '0;
      for (int i = 0; i < STAGES; i++) begin
        ent_a3[i]   <= '0;
        ent_tnew[i] <= '0;
      end
    end else if (bus.flush) begin
      ent_v <= '0;
    end else begin
      for (int i = 1; i < STAGES; i++) begin
        ent_v[i]    <= ent_v[i-1];
        ent_a3[i]   <= ent_a3[i-1];
        ent_tnew[i] <= sat_dec(ent_tnew[i-1]);
      end
      ent_v[0]    <= bus.issue_valid && (bus.issue_a3 != '0) && !stall_int;
      ent_a3[0]   <= bus.issue_a3;
      ent_tnew[0] <= bus.issue_tnew;
    end
  end

  // Scan oldest to youngest so the youngest matching entry is the one left standing.
  always_comb begin
    match = '0;
    for (int p = 0; p < NRD; p++) begin
      m_tnew[p] = '0;
      m_wd[p]   = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
        if (ent_v[i] && (ent_a3[i] == bus.rd_addr[p*AW +: AW]) &&
            (bus.rd_addr[p*AW +: AW] != '0)) begin
          match[p]  = 1'b1;
          m_tnew[p] = ent_tnew[i];
          m_wd[p]   = bus.stage_wd[i*DW +: DW];
        end
      end
    end
  end

  always_comb begin
    stall_int      = 1'b0;
    fwd            = '0;
    bus.rd_val1    = bus.rd_val0;
    bus.rd_pending = '0;
    for (int p = 0; p < NRD; p++) begin
      if (match[p]) begin
        if (m_tnew[p] == '0) begin
          fwd[p]                   = 1'b1;
          bus.rd_val1[p*DW +: DW]  = m_wd[p];
        end else begin
          bus.rd_pending[p] = 1'b1;
        end
        if (m_tnew[p] > bus.rd_tuse[p*TW +: TW]) stall_int = 1'b1;
      end
    end
  end

  assign bus.stall = stall_int;

`ifdef FWD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] fwd_cnt_q;
  logic [31:0] fwd_now;

  always_comb begin
    fwd_now = '0;
    for (int p = 0; p < NRD; p++) fwd_now = fwd_now + 32'(fwd[p]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall_int && !bus.flush) stall_cnt_q <= stall_cnt_q + 32'd1;
      fwd_cnt_q <= fwd_cnt_q + fwd_now;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;
`else
  assign bus.stall_cnt = 32'd0;
  assign bus.fwd_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Directed testbench for fwd_hazard_tracker: forwarding, load-use stall, youngest-wins,
// $0 handling, flush and asynchronous reset.
module tb_fwd_hazard_tracker;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int STAGES = 3;
  localparam int NRD = 2;
  localparam int TW = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fwd_hazard_if #(.DW(DW), .AW(AW), .STAGES(STAGES), .NRD(NRD), .TW(TW)) bus ();

  fwd_hazard_tracker #(.DW(DW), .AW(AW), .STAGES(STAGES), .NRD(NRD), .TW(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.flush       = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_a3    = '0;
    bus.issue_tnew  = '0;
    bus.stage_wd    = '0;
    bus.rd_addr     = '0;
    bus.rd_tuse     = '0;
    bus.rd_val0     = {32'h2222_2222, 32'h1111_1111};
  endtask

  task automatic drain();
    clear_inputs();
    repeat (STAGES) tick();
  endtask

  task automatic issue(input logic [AW-1:0] a3, input logic [TW-1:0] tnew);
    bus.issue_valid = 1'b1;
    bus.issue_a3    = a3;
    bus.issue_tnew  = tnew;
    tick();
    bus.issue_valid = 1'b0;
    bus.issue_a3    = '0;
    bus.issue_tnew  = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %0b want 0", bus.stall);
    end
    n_checks++;
    if (bus.rd_pending !== 2'b00) begin
      n_fail++; $display("FAIL reset_pending: got %b want 00", bus.rd_pending);
    end
    n_checks++;
    if (bus.rd_val1 !== 64'h2222_2222_1111_1111) begin
      n_fail++; $display("FAIL reset_val1: got %h want 2222222211111111", bus.rd_val1);
    end
    n_checks++;
    if (bus.stall_cnt !== 32'd0 || bus.fwd_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.stall_cnt, bus.fwd_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_forward_e();
    drain();
    issue(5'd5, 2'd0);
    bus.rd_addr[0 +: AW]    = 5'd5;
    bus.stage_wd[0 +: DW]   = 32'h0000_1234;
    bus.rd_val0[0 +: DW]    = 32'h0000_DEAD;
    #1;
    n_checks++;
    if (bus.rd_val1[0 +: DW] !== 32'h0000_1234) begin
      n_fail++; $display("FAIL fwd_e_val: got %h want 00001234", bus.rd_val1[0 +: DW]);
    end
    n_checks++;
    if (bus.stall !== 1'b0 || bus.rd_pending !== 2'b00) begin
      n_fail++; $display("FAIL fwd_e_status: got stall=%0b pend=%b want 0/00", bus.stall, bus.rd_pending);
    end
    n_checks++;
    if (bus.rd_val1[DW +: DW] !== 32'h2222_2222) begin
      n_fail++; $display("FAIL fwd_e_port1: got %h want 22222222", bus.rd_val1[DW +: DW]);
    end
  endtask

  task automatic test_load_use();
    logic [31:0] s0, f0;
    drain();
    s0 = bus.stall_cnt;
    f0 = bus.fwd_cnt;
    issue(5'd8, 2'd2);
    // cycle 1: producer in E, tnew=2 > tuse=0
    bus.rd_addr[0 +: AW] = 5'd8;
    bus.rd_tuse[0 +: TW] = 2'd0;
    #1;
    n_checks++;
    if (bus.stall !== 1'b1 || bus.rd_pending !== 2'b01) begin
      n_fail++; $display("FAIL lu_c1: got stall=%0b pend=%b want 1/01", bus.stall, bus.rd_pending);
    end
    n_checks++;
    if (bus.rd_val1[0 +: DW] !== 32'h1111_1111) begin
      n_fail++; $display("FAIL lu_c1_val: got %h want 11111111", bus.rd_val1[0 +: DW]);
    end
    // an issue offered while stalled must be dropped
    bus.issue_valid = 1'b1;
    bus.issue_a3    = 5'd9;
    bus.issue_tnew  = 2'd0;
    tick();
    bus.issue_valid = 1'b0;
    bus.rd_addr[DW/DW*AW +: AW] = 5'd9;
    bus.rd_tuse[TW +: TW]       = 2'd3;
    bus.stage_wd[0 +: DW]       = 32'h0000_9999;
    #1;
    n_checks++;
    if (bus.stall !== 1'b1 || bus.rd_pending !== 2'b01) begin
      n_fail++; $display("FAIL lu_c2: got stall=%0b pend=%b want 1/01", bus.stall, bus.rd_pending);
    end
    n_checks++;
    if (bus.rd_val1[DW +: DW] !== 32'h2222_2222) begin
      n_fail++; $display("FAIL lu_dropped_issue: got %h want 22222222", bus.rd_val1[DW +: DW]);
    end
    tick();
    bus.rd_addr[AW +: AW]       = 5'd0;
    bus.stage_wd[2*DW +: DW]    = 32'h0000_CAFE;
    #1;
    n_checks++;
    if (bus.stall !== 1'b0 || bus.rd_pending !== 2'b00) begin
      n_fail++; $display("FAIL lu_c3: got stall=%0b pend=%b want 0/00", bus.stall, bus.rd_pending);
    end
    n_checks++;
    if (bus.rd_val1[0 +: DW] !== 32'h0000_CAFE) begin
      n_fail++; $display("FAIL lu_c3_val: got %h want 0000cafe", bus.rd_val1[0 +: DW]);
    end
    tick();
`ifdef FWD_STATS_EN
    n_checks++;
    if (bus.stall_cnt - s0 !== 32'd2 || bus.fwd_cnt - f0 !== 32'd1) begin
      n_fail++; $display("FAIL lu_stats: got %0d/%0d want 2/1", bus.stall_cnt - s0, bus.fwd_cnt - f0);
    end
`else
    n_checks++;
    if (bus.stall_cnt !== 32'd0 || bus.fwd_cnt !== 32'd0 || s0 !== 32'd0 || f0 !== 32'd0) begin
      n_fail++; $display("FAIL lu_stats_off: got %0d/%0d want 0/0", bus.stall_cnt, bus.fwd_cnt);
    end
`endif
  endtask

  task automatic test_youngest();
    drain();
    issue(5'd3, 2'd0);
    issue(5'd3, 2'd0);
    bus.rd_addr[0 +: AW]     = 5'd3;
    bus.stage_wd[0 +: DW]    = 32'h0000_000A;
    bus.stage_wd[DW +: DW]   = 32'h0000_000B;
    #1;
    n_checks++;
    if (bus.rd_val1[0 +: DW] !== 32'h0000_000A) begin
      n_fail++; $display("FAIL youngest_val: got %h want 0000000a", bus.rd_val1[0 +: DW]);
    end
    // younger producer still pending hides an older ready one; tnew == tuse does not stall
    drain();
    issue(5'd4, 2'd0);
    issue(5'd4, 2'd3);
    bus.rd_addr[0 +: AW]   = 5'd4;
    bus.rd_tuse[0 +: TW]   = 2'd3;
    bus.stage_wd[DW +: DW] = 32'h0000_0BBB;
    #1;
    n_checks++;
    if (bus.rd_pending !== 2'b01 || bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL youngest_pend: got pend=%b stall=%0b want 01/0", bus.rd_pending, bus.stall);
    end
    n_checks++;
    if (bus.rd_val1[0 +: DW] !== 32'h1111_1111) begin
      n_fail++; $display("FAIL youngest_pend_val: got %h want 11111111", bus.rd_val1[0 +: DW]);
    end
  endtask

  task automatic test_reg_zero();
    drain();
    issue(5'd0, 2'd3);
    bus.rd_addr[0 +: AW]  = 5'd0;
    bus.rd_tuse[0 +: TW]  = 2'd0;
    bus.rd_addr[AW +: AW] = 5'd7;
    bus.stage_wd          = {3{32'h5555_5555}};
    #1;
    n_checks++;
    if (bus.stall !== 1'b0 || bus.rd_pending !== 2'b00) begin
      n_fail++; $display("FAIL zero_status: got stall=%0b pend=%b want 0/00", bus.stall, bus.rd_pending);
    end
    n_checks++;
    if (bus.rd_val1 !== 64'h2222_2222_1111_1111) begin
      n_fail++; $display("FAIL zero_val: got %h want 2222222211111111", bus.rd_val1);
    end
  endtask

  task automatic test_flush();
    drain();
    issue(5'd8, 2'd2);
    bus.rd_addr[0 +: AW] = 5'd8;
    bus.rd_tuse[0 +: TW] = 2'd0;
    #1;
    n_checks++;
    if (bus.stall !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre: got stall=%0b want 1", bus.stall);
    end
    bus.flush       = 1'b1;
    bus.issue_valid = 1'b1;
    bus.issue_a3    = 5'd6;
    bus.issue_tnew  = 2'd0;
    tick();
    bus.flush       = 1'b0;
    bus.issue_valid = 1'b0;
    bus.rd_addr[AW +: AW] = 5'd6;
    bus.stage_wd[0 +: DW] = 32'h0000_6666;
    #1;
    n_checks++;
    if (bus.stall !== 1'b0 || bus.rd_pending !== 2'b00) begin
      n_fail++; $display("FAIL flush_post: got stall=%0b pend=%b want 0/00", bus.stall, bus.rd_pending);
    end
    n_checks++;
    if (bus.rd_val1 !== 64'h2222_2222_1111_1111) begin
      n_fail++; $display("FAIL flush_val: got %h want 2222222211111111", bus.rd_val1);
    end
  endtask

  task automatic test_async_reset();
    drain();
    issue(5'd8, 2'd3);
    bus.rd_addr[0 +: AW] = 5'd8;
    bus.rd_tuse[0 +: TW] = 2'd0;
    tick();
    n_checks++;
    if (bus.stall !== 1'b1 || bus.rd_pending !== 2'b01) begin
      n_fail++; $display("FAIL areset_pre: got stall=%0b pend=%b want 1/01", bus.stall, bus.rd_pending);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.stall !== 1'b0 || bus.rd_pending !== 2'b00) begin
      n_fail++; $display("FAIL areset_status: got stall=%0b pend=%b want 0/00", bus.stall, bus.rd_pending);
    end
    n_checks++;
    if (bus.rd_val1 !== bus.rd_val0 || bus.rd_val1 !== 64'h2222_2222_1111_1111) begin
      n_fail++; $display("FAIL areset_val: got %h want 2222222211111111", bus.rd_val1);
    end
    n_checks++;
    if (bus.stall_cnt !== 32'd0 || bus.fwd_cnt !== 32'd0) begin
      n_fail++; $display("FAIL areset_cnt: got %0d/%0d want 0/0", bus.stall_cnt, bus.fwd_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    test_reset();
    test_forward_e();
    test_load_use();
    test_youngest();
    test_reg_zero();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
